// File: rtl/phy_tx_nlane.sv
// phy_tx_nlane: N-lane transmit PHY.
// Collects NCH lanes of DW-bit words once per frame. Each word is sent as one
// time slot on a single serial line. Empty or invalid slots are filled with
// IDLE_SYM. A detector on serial_in looks for aligned IDLE_SYM words and
// declares the link active. Before that, the line carries only IDLE_SYM and
// input words are recirculated on rec_data/rec_valid.
// Optional build macro PHY_TX_LSB_FIRST_EN sends each slot LSB first. The
// detector then shifts LSB first as well. Without the macro, both directions
// are MSB first.
//
// Detector states:
//   state    | meaning
//   S_SEARCH | compare the shift register on every bit, looking for IDLE_SYM
//   S_COUNT  | word-aligned; compare once per DW bits, count matches
//   S_ACTIVE | link declared active; terminal until reset
module phy_tx_nlane #(
    parameter int              NCH      = 4,
    parameter int              DW       = 8,
    parameter logic [DW-1:0]   IDLE_SYM = 8'hBC,
    parameter int              DET_CNT  = 4
) (
    input  logic                clk_32f,
    input  logic                rst,
    input  logic [NCH*DW-1:0]   in_data,
    input  logic [NCH-1:0]      in_valid,
    input  logic                serial_in,
    output logic                tx_serial,
    output logic                frame_start,
    output logic                active,
    output logic [NCH*DW-1:0]   rec_data,
    output logic [NCH-1:0]      rec_valid
);

    localparam int F   = NCH * DW;
    localparam int BW  = $clog2(F);
    localparam int SW  = $clog2(NCH);
    localparam int DBW = $clog2(DW);
    localparam logic [BW-1:0]  BCNT_LAST = BW'(F - 1);
    localparam logic [SW-1:0]  SLOT_LAST = SW'(NCH - 1);
    localparam logic [DBW-1:0] BIT_LAST  = DBW'(DW - 1);
    localparam logic [3:0]     DET_TGT   = 4'(DET_CNT);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_COUNT  = 2'd1,
        S_ACTIVE = 2'd2
    } det_state_t;

    // Frame position: bcnt frames the line, while slot/bidx give the same
    // position split into lane index and bit-within-word. This avoids a
    // divider when DW is not a power of two.
    logic [BW-1:0]   bcnt;
    logic [SW-1:0]   slot;
    logic [DBW-1:0]  bidx;
    logic            load;

    logic [F-1:0]    shadow_data;
    logic [NCH-1:0]  shadow_valid;
    logic            mode;

    logic [DW-1:0]   cur_sym;
    logic            cur_bit;

    det_state_t      state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;
    logic [DBW-1:0]  ph, ph_nxt;
    logic [DW-1:0]   sr, sr_nxt;
    logic            match;
    logic            active_nxt;

    assign load = (bcnt == BCNT_LAST);

`ifdef PHY_TX_LSB_FIRST_EN
    assign sr_nxt = {serial_in, sr[DW-1:1]};
`else
    assign sr_nxt = {sr[DW-2:0], serial_in};
`endif

    assign match = (sr_nxt == IDLE_SYM);

    // Pick the symbol for the current slot and the bit of it on the line now.
    always_comb begin
        cur_sym = IDLE_SYM;
        if (mode && shadow_valid[slot])
            cur_sym = shadow_data[int'(slot)*DW +: DW];
`ifdef PHY_TX_LSB_FIRST_EN
        cur_bit = cur_sym[bidx];
`else
        cur_bit = cur_sym[BIT_LAST - bidx];
`endif
    end

    // Frame counter, shadow load, recirculation and registered line output.
    always_ff @(posedge clk_32f) begin
        if (!rst) begin
            bcnt         <= BCNT_LAST;
            slot         <= SLOT_LAST;
            bidx         <= BIT_LAST;
            shadow_data  <= '0;
            shadow_valid <= '0;
            mode         <= 1'b0;
            tx_serial    <= 1'b0;
            frame_start  <= 1'b0;
            rec_data     <= '0;
            rec_valid    <= '0;
        end else begin
            tx_serial   <= cur_bit;
            frame_start <= (bcnt == '0);
            if (load) begin
                bcnt         <= '0;
                slot         <= '0;
                bidx         <= '0;
                shadow_data  <= in_data;
                shadow_valid <= in_valid;
                // Use the same-edge active value so a frame never mixes modes.
                mode         <= active_nxt;
                if (active_nxt) begin
                    rec_valid <= '0;
                end else begin
                    rec_data  <= in_data;
                    rec_valid <= in_valid;
                end
            end else begin
                bcnt <= bcnt + 1'b1;
                if (bidx == BIT_LAST) begin
                    bidx <= '0;
                    slot <= slot + 1'b1;
                end else begin
                    bidx <= bidx + 1'b1;
                end
            end
        end
    end

    // Detector state register, including the shift register and the sticky active flag.
    always_ff @(posedge clk_32f) begin
        if (!rst) begin
            state  <= S_SEARCH;
            cnt    <= '0;
            ph     <= '0;
            sr     <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            ph     <= ph_nxt;
            sr     <= sr_nxt;
            active <= active_nxt;
        end
    end

    // Detector next state: search bit-by-bit, then verify once per word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ph_nxt    = ph;
        case (state)
            S_SEARCH: begin
                if (match) begin
                    cnt_nxt = 4'd1;
                    ph_nxt  = '0;
                    if (DET_TGT == 4'd1)
                        state_nxt = S_ACTIVE;
                    else
                        state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (ph == BIT_LAST) begin
                    ph_nxt = '0;
                    if (match) begin
                        cnt_nxt = cnt + 4'd1;
                        if (cnt + 4'd1 == DET_TGT)
                            state_nxt = S_ACTIVE;
                    end else begin
                        cnt_nxt   = '0;
                        state_nxt = S_SEARCH;
                    end
                end else begin
                    ph_nxt = ph + 1'b1;
                end
            end
            S_ACTIVE: begin
                state_nxt = S_ACTIVE;
            end
            default: begin
                state_nxt = S_SEARCH;
                cnt_nxt   = '0;
            end
        endcase
        active_nxt = active | (state_nxt == S_ACTIVE);
    end

endmodule

// File: tb/tb_phy_tx_nlane.sv
// Directed bench for phy_tx_nlane.
// dut1 uses the default parameters (4 lanes x 8 bits).
// dut2 uses 8 lanes x 4 bits, IDLE 4'h5 and DET_CNT=1.
// Captured frames are packed with the first bit on the line at the MSB.
module tb_phy_tx_nlane;

`ifdef PHY_TX_LSB_FIRST_EN
    localparam logic [7:0]  W_IDLE    = 8'h3D;
    localparam logic [31:0] EXP_IDLE1 = 32'h3D3D3D3D;
    localparam logic [31:0] EXP_DATA1 = 32'h853DC32B;
    localparam logic [3:0]  W_IDLE2   = 4'hA;
    localparam logic [31:0] EXP_IDLE2 = 32'hAAAAAAAA;
    localparam logic [31:0] EXP_DATA2 = 32'hA54AC32B;
`else
    localparam logic [7:0]  W_IDLE    = 8'hBC;
    localparam logic [31:0] EXP_IDLE1 = 32'hBCBCBCBC;
    localparam logic [31:0] EXP_DATA1 = 32'hA1BCC3D4;
    localparam logic [3:0]  W_IDLE2   = 4'h5;
    localparam logic [31:0] EXP_IDLE2 = 32'h55555555;
    localparam logic [31:0] EXP_DATA2 = 32'h5A253C4D;
`endif

    logic        clk_32f = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic [7:0]  in_valid2;
    logic        serial_in, serial_in2;
    logic        tx_serial, frame_start, active;
    logic [31:0] rec_data;
    logic [3:0]  rec_valid;
    logic        tx_serial2, frame_start2, active2;
    logic [31:0] rec_data2;
    logic [7:0]  rec_valid2;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk_32f = ~clk_32f;

    phy_tx_nlane dut1 (
        .clk_32f     (clk_32f),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .serial_in   (serial_in),
        .tx_serial   (tx_serial),
        .frame_start (frame_start),
        .active      (active),
        .rec_data    (rec_data),
        .rec_valid   (rec_valid)
    );

    phy_tx_nlane #(.NCH(8), .DW(4), .IDLE_SYM(4'h5), .DET_CNT(1)) dut2 (
        .clk_32f     (clk_32f),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid2),
        .serial_in   (serial_in2),
        .tx_serial   (tx_serial2),
        .frame_start (frame_start2),
        .active      (active2),
        .rec_data    (rec_data2),
        .rec_valid   (rec_valid2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic b2);
        serial_in  = b;
        serial_in2 = b2;
        tick();
    endtask

    // Sends a word in wire order: bit 7 of w goes on the line first.
    task automatic send_wire(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    endtask

    task automatic wait_frame(output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (!frame_start && waited < 100);
        check("fs_seen", 64'(frame_start), 64'd1);
    endtask

    task automatic capture(output logic [31:0] v1, output logic [31:0] v2, output int extra_fs);
        v1 = '0;
        v2 = '0;
        extra_fs = 0;
        v1[31] = tx_serial;
        v2[31] = tx_serial2;
        for (int k = 1; k < 32; k++) begin
            tick();
            v1[31-k] = tx_serial;
            v2[31-k] = tx_serial2;
            if (frame_start || frame_start2) extra_fs++;
        end
    endtask

    initial begin
        logic [31:0] v1, v2;
        logic [63:0] rem;
        int          waited, extra, t;

        // Hold reset with random inputs.
        rst = 1'b0;
        serial_in = 1'b0;
        serial_in2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data    = $urandom;
            in_valid   = 4'($urandom);
            in_valid2  = 8'($urandom);
            serial_in  = 1'($urandom_range(0, 1));
            serial_in2 = 1'($urandom_range(0, 1));
            tick();
        end
        check("rst_tx", 64'(tx_serial), 64'd0);
        check("rst_fs", 64'(frame_start), 64'd0);
        check("rst_active", 64'(active), 64'd0);
        check("rst_rec_data", 64'(rec_data), 64'd0);
        check("rst_rec_valid", 64'(rec_valid), 64'd0);
        check("rst_active2", 64'(active2), 64'd0);
        check("rst_rec_data2", 64'(rec_data2), 64'd0);

        // Pre-active: recirculation on the first load edge, and a line of IDLE only.
        in_data    = 32'h44332211;
        in_valid   = 4'hF;
        in_valid2  = 8'hFF;
        serial_in  = 1'b0;
        serial_in2 = 1'b0;
        rst        = 1'b1;
        tick();
        check("rec_data_pre", 64'(rec_data), 64'h44332211);
        check("rec_valid_pre", 64'(rec_valid), 64'hF);
        check("rec_data2_pre", 64'(rec_data2), 64'h44332211);
        check("fs_not_first_edge", 64'(frame_start), 64'd0);
        wait_frame(waited);
        check("fs_latency", 64'(waited), 64'd1);
        check("fs2_align", 64'(frame_start2), 64'd1);
        capture(v1, v2, extra);
        check("idle_frame1", 64'(v1), 64'(EXP_IDLE1));
        check("idle_frame2", 64'(v2), 64'(EXP_IDLE2));
        check("fs_single_pulse", 64'(extra), 64'd0);

        // Detection with a corrupted third word: the detector must not go active.
        send_rand(3);
        send_wire(W_IDLE);
        send_wire(W_IDLE);
        send_wire(8'h00);
        send_wire(W_IDLE);
        check("corrupt_no_active", 64'(active), 64'd0);

        // Flush dut1 back to SEARCH while dut2 (DET_CNT=1) detects a single word.
        for (int i = 0; i < 8; i++) begin
            send_bit(1'b0, (i < 4) ? W_IDLE2[3-i] : 1'b0);
            if (i == 2) check("det1_before", 64'(active2), 64'd0);
            if (i == 3) check("det1_after", 64'(active2), 64'd1);
        end

        // Successful detection, with active traffic loaded for the next frames.
        in_data   = 32'hD4C3B2A1;
        in_valid  = 4'b1101;
        in_valid2 = 8'b1111_0110;
        send_rand(3);
        for (int w = 0; w < 3; w++) send_wire(W_IDLE);
        for (int i = 7; i >= 1; i--) send_bit(W_IDLE[i], 1'b0);
        check("active_before_last_bit", 64'(active), 64'd0);
        send_bit(W_IDLE[0], 1'b0);
        check("active_on_last_bit", 64'(active), 64'd1);
        serial_in = 1'b0;

        // The rest of the frame in flight stays IDLE.
        t = 0;
        rem = '0;
        while (!frame_start && t < 40) begin
            rem = {rem[62:0], tx_serial};
            t++;
            tick();
        end
        check("tail_len", 64'(t), 64'd19);
        check("tail_idle", rem, 64'(EXP_IDLE1) & ((64'd1 << t) - 64'd1));

        // The next frame carries data.
        capture(v1, v2, extra);
        check("data_frame1", 64'(v1), 64'(EXP_DATA1));
        check("data_frame2", 64'(v2), 64'(EXP_DATA2));
        check("fs_single_pulse2", 64'(extra), 64'd0);
        check("rec_valid_frozen", 64'(rec_valid), 64'd0);
        check("rec_data_held", 64'(rec_data), 64'hD4C3B2A1);
        check("rec_valid2_frozen", 64'(rec_valid2), 64'd0);
        check("rec_data2_held", 64'(rec_data2), 64'h44332211);

        // Reset in the middle of a frame, at bcnt=13.
        for (int i = 0; i < 13; i++) tick();
        rst = 1'b0;
        tick();
        check("mid_rst_tx", 64'(tx_serial), 64'd0);
        check("mid_rst_fs", 64'(frame_start), 64'd0);
        check("mid_rst_active", 64'(active), 64'd0);
        check("mid_rst_active2", 64'(active2), 64'd0);
        check("mid_rst_rec_valid", 64'(rec_valid), 64'd0);
        check("mid_rst_rec_data", 64'(rec_data), 64'd0);
        tick();
        rst = 1'b1;
        wait_frame(waited);
        check("restart_fs_latency", 64'(waited), 64'd2);
        capture(v1, v2, extra);
        check("restart_idle1", 64'(v1), 64'(EXP_IDLE1));
        check("restart_idle2", 64'(v2), 64'(EXP_IDLE2));
        check("restart_active", 64'(active), 64'd0);

        // After reset the detector searches again from scratch.
        for (int w = 0; w < 3; w++) send_wire(W_IDLE);
        check("redetect_before", 64'(active), 64'd0);
        send_wire(W_IDLE);
        check("redetect_after", 64'(active), 64'd1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
